// File: rtl/apb_slave_mux_n.sv
// APB3 fan-out from one requester to NUM_PORTS completers. The port index is latched in
// the setup phase, unmapped or disabled ports get an in-block error, and a watchdog aborts hung completers.
module apb_slave_mux_n #(
    parameter int                   NUM_PORTS = 4,
    parameter int                   SEL_W     = 2,
    parameter int                   ADDR_W    = 32,
    parameter int                   DATA_W    = 32,
    parameter logic [NUM_PORTS-1:0] PORT_EN   = {NUM_PORTS{1'b1}},
    parameter int                   TIMEOUT   = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic [SEL_W-1:0]            DECODE,
    input  logic [ADDR_W-1:0]           PADDR,
    input  logic                        PWRITE,
    input  logic                        PSEL,
    input  logic                        PENABLE,
    input  logic [DATA_W-1:0]           PWDATA,
    output logic [DATA_W-1:0]           PRDATA,
    output logic                        PREADY,
    output logic                        PSLVERR,
    output logic [ADDR_W-1:0]           PADDR_S,
    output logic                        PWRITE_S,
    output logic [DATA_W-1:0]           PWDATA_S,
    output logic [NUM_PORTS-1:0]        PSEL_S,
    output logic [NUM_PORTS-1:0]        PENABLE_S,
    input  logic [NUM_PORTS*DATA_W-1:0] PRDATA_S,
    input  logic [NUM_PORTS-1:0]        PREADY_S,
    input  logic [NUM_PORTS-1:0]        PSLVERR_S,
    output logic                        timeout_flag,
    output logic [SEL_W-1:0]            timeout_port,
    input  logic                        timeout_clr
);

    localparam int             WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit             WD_ON   = (TIMEOUT > 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ABORT} state_t;

    state_t            state_q, state_d, phase;
    logic [SEL_W-1:0]  port_q;
    logic              valid_q;
    logic [WD_W-1:0]   wdog_q;

    logic              sel_ready, sel_err;
    logic [DATA_W-1:0] sel_rdata;
    logic              wait_cyc, expire;
    logic [NUM_PORTS-1:0] psel_s, penable_s;
    logic              any_sel;

    function automatic logic port_ok(input logic [SEL_W-1:0] sel);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (sel == SEL_W'(i)) ok = PORT_EN[i];
        return ok;
    endfunction

    // The setup phase is decoded from the live bus while idle, so a transfer costs no extra
    // cycle and back-to-back transfers re-enter setup straight from IDLE.
    always_comb begin
        phase = state_q;
        if (state_q == IDLE && PSEL && !PENABLE && PRESETn)
            phase = SETUP;
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (port_q == SEL_W'(i)) begin
                sel_ready = PREADY_S[i];
                sel_err   = PSLVERR_S[i];
                sel_rdata = PRDATA_S[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wait_cyc = (phase == ACCESS) && PSEL && valid_q && !sel_ready;
    // A ready arriving on the last allowed cycle completes normally, since wait_cyc is then low.
    assign expire   = WD_ON && wait_cyc && (wdog_q == WD_LAST);

    always_comb begin
        state_d   = state_q;
        psel_s    = '0;
        penable_s = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        case (phase)
            IDLE: state_d = IDLE;
            SETUP: begin
                state_d = ACCESS;
                for (int i = 0; i < NUM_PORTS; i++)
                    if (DECODE == SEL_W'(i) && port_ok(DECODE)) psel_s[i] = 1'b1;
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (!valid_q) begin
                    PREADY  = 1'b1;
                    PSLVERR = 1'b1;
                    state_d = IDLE;
                end else begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (port_q == SEL_W'(i)) begin
                            psel_s[i]    = 1'b1;
                            penable_s[i] = PENABLE;
                        end
                    end
                    PREADY  = sel_ready;
                    PSLVERR = sel_ready & sel_err;
                    PRDATA  = sel_ready ? sel_rdata : '0;
                    if (sel_ready)   state_d = IDLE;
                    else if (expire) state_d = ABORT;
                end
            end
            ABORT: begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign PSEL_S    = psel_s;
    assign PENABLE_S = penable_s;
    assign any_sel   = |psel_s;
    assign PADDR_S   = any_sel ? PADDR  : '0;
    assign PWRITE_S  = any_sel ? PWRITE : 1'b0;
    assign PWDATA_S  = any_sel ? PWDATA : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            port_q       <= '0;
            valid_q      <= 1'b0;
            wdog_q       <= '0;
            timeout_flag <= 1'b0;
            timeout_port <= '0;
        end else begin
            state_q <= state_d;
            if (phase == SETUP) begin
                port_q  <= DECODE;
                valid_q <= port_ok(DECODE);
                wdog_q  <= '0;
            end else if (wait_cyc) begin
                wdog_q  <= wdog_q + WD_W'(1);
            end
            if (expire) begin
                timeout_flag <= 1'b1;
                timeout_port <= port_q;
            end else if (timeout_clr) begin
                timeout_flag <= 1'b0;
            end
        end
    end

endmodule

// File: doc/apb_slave_mux_n.md
Name: apb_slave_mux_n

Overview:
- Parametrised APB3 fan-out: one upstream APB requester, NUM_PORTS downstream completers.
- Generalises the fixed 4-port combinational mux: parametrised width and port count, and a port index latched at the setup phase.
- Adds an in-block error response for unmapped or disabled ports and a per-transfer watchdog that aborts hung completers.
- Sits between the APB bridge and the peripheral completers (SPI master, timers, GPIO).

Parameters:
- NUM_PORTS, 4, number of downstream ports (2..16).
- SEL_W, 2, width of DECODE; must satisfy 2**SEL_W >= NUM_PORTS.
- ADDR_W, 32, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width.
- PORT_EN, {NUM_PORTS{1'b1}}, bit i = 1 enables port i.
- TIMEOUT, 16, access-phase wait cycles before abort; 0 disables the watchdog.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- DECODE  in  SEL_W  port index from the address decoder, valid with PSEL.
- PADDR  in  ADDR_W  upstream address.
- PWRITE  in  1  upstream write strobe.
- PSEL  in  1  upstream select.
- PENABLE  in  1  upstream enable.
- PWDATA  in  DATA_W  upstream write data.
- PRDATA  out  DATA_W  read data to the requester.
- PREADY  out  1  ready to the requester.
- PSLVERR  out  1  error to the requester.
- PADDR_S  out  ADDR_W  broadcast address, zero when no port is selected.
- PWRITE_S  out  1  broadcast write, zero when no port is selected.
- PWDATA_S  out  DATA_W  broadcast write data, zero when no port is selected.
- PSEL_S  out  NUM_PORTS  one-hot downstream select.
- PENABLE_S  out  NUM_PORTS  one-hot downstream enable.
- PRDATA_S  in  NUM_PORTS*DATA_W  completer read data; port i occupies bits [i*DATA_W +: DATA_W].
- PREADY_S  in  NUM_PORTS  completer ready.
- PSLVERR_S  in  NUM_PORTS  completer error.
- timeout_flag  out  1  sticky: at least one transfer was aborted by the watchdog.
- timeout_port  out  SEL_W  index of the most recently aborted port.
- timeout_clr  in  1  single-cycle pulse; clears timeout_flag.

Behaviour:
- Reset (async assert, sync deassert taken by the caller):
  - state=IDLE, port_q=0, wdog=0, timeout_flag=0, timeout_port=0.
  - All PSEL_S, PENABLE_S = 0; PREADY=0, PSLVERR=0, PRDATA=0.
- FSM states:
  - IDLE -> SETUP on PSEL & ~PENABLE.
  - SETUP -> ACCESS unconditionally on the next edge. port_q <= DECODE. valid_q <= (DECODE < NUM_PORTS) & PORT_EN[DECODE].
  - ACCESS, valid_q=1: stay while PREADY_S[port_q]=0 and the watchdog has not fired. On PREADY_S[port_q]=1: go to SETUP if PSEL & ~PENABLE is sampled that cycle (back-to-back), else IDLE.
  - ACCESS, valid_q=0: complete in the first access cycle, then same exit rule as above.
  - ABORT: one cycle; PREADY=1, PSLVERR=1, PRDATA=0; then IDLE.
- Setup phase: PSEL_S[DECODE]=1 combinationally, only if the port is valid. PENABLE_S all 0.
- Access phase, valid port:
  - PSEL_S[port_q]=1 and PENABLE_S[port_q]=PENABLE.
  - DECODE changes after setup are ignored.
  - PREADY=PREADY_S[port_q], PSLVERR=PREADY_S[port_q] & PSLVERR_S[port_q], PRDATA=PRDATA_S[port_q]. Zero added latency.
- Access phase, invalid port: no downstream PSEL_S. PREADY=1, PSLVERR=1, PRDATA=0 in the first access cycle (one-wait-free error).
- Broadcast gating: PADDR_S, PWRITE_S, PWDATA_S equal the upstream values whenever any PSEL_S bit is high, else 0.
- Watchdog (TIMEOUT>0):
  - wdog clears on entering ACCESS and increments each access cycle with PREADY_S[port_q]=0.
  - When wdog==TIMEOUT-1 and PREADY_S is still 0: drop PSEL_S and PENABLE_S next cycle, enter ABORT, set timeout_flag=1, timeout_port=port_q.
  - A PREADY_S arriving in the same cycle as expiry wins: normal completion, no abort.
- timeout_clr arriving in the same cycle as a new abort: the set wins.
- Upstream PSEL dropping mid-access (protocol violation): return to IDLE next cycle, downstream signals low, no flag.
- PRDATA and PSLVERR are 0 whenever PREADY=0.

Test Plan:
- Write to port 2, PREADY_S[2]=1 in the first access cycle -> PSEL_S=4'b0100 for 2 cycles, PENABLE_S=4'b0100 in the access cycle, PREADY=1, PSLVERR=0, total 2 cycles.
- Read from port 1 with 3 wait states, PRDATA_S[1]=32'hA5A5_0001; DECODE changed to 3 during the waits -> PRDATA=32'hA5A5_0001 on cycle 5, PSEL_S never 4'b1000.
- PORT_EN=4'b1011, access to port 2 -> no PSEL_S bit set, PREADY=1, PSLVERR=1, PRDATA=0 in the access cycle.
- TIMEOUT=4, port 0 never ready -> PSEL_S[0] drops after 4 access cycles, ABORT with PREADY=PSLVERR=1, timeout_flag=1, timeout_port=0; timeout_clr pulse -> flag=0.
- Back-to-back transfers (port 3 then port 0) with no idle cycle -> each completes in 2 cycles, PSEL_S switches 4'b1000 -> 4'b0001.
- PRESETn asserted mid-access on port 1 -> all outputs 0 immediately; the next transfer works normally after release.
